regfile_access_ctrl: RTL
========================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have parameter LAT_FAST, default 2, read latency in cycles for mode 0 (>=1).
REQ-003 SHALL have parameter LAT_SLOW, default 3, read latency in cycles for mode 1 (>=1).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, controller accepts request.
REQ-008 SHALL have ports req_write (input, 1, 1=write), req_mode (input, 1, latency select), req_addr (input, 5) and req_wdata (input, WIDTH).
REQ-009 SHALL have port rsp_valid, output, 1, response present.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-011 SHALL have ports rsp_data (output, WIDTH) and rsp_err (output, 1, verify mismatch).
REQ-012 SHALL have register-file-side ports rf_write_enable (output, 1), rf_address (output, 5), rf_datain (output, WIDTH), rf_mode (output, 1) and rf_dataout (input, WIDTH).
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, WRITE, READ_WAIT and RESP, all state and outputs registered.
REQ-015 SHALL drive req_ready high only in IDLE; a request is accepted on an edge with req_valid and req_ready both high.
REQ-016 SHALL latch write, mode, addr and wdata on accept, and drive them on rf_address, rf_datain and rf_mode from the next cycle until the transaction returns to IDLE.
REQ-017 SHALL hold rf_mode and rf_address at their last values while in IDLE.
REQ-018 On an accepted write, SHALL go IDLE->WRITE, assert rf_write_enable for exactly that one cycle, then go to RESP with rsp_data = wdata, so that rsp_valid rises 1 cycle after accept.
REQ-019 On an accepted read, SHALL go IDLE->READ_WAIT and load a down-counter with LAT-1, where LAT = LAT_SLOW if mode=1 and LAT_FAST otherwise.
REQ-020 In READ_WAIT, SHALL decrement the counter each cycle; on the edge where the counter is 0, it SHALL capture rf_dataout into rsp_data and go to RESP, so that rsp_valid rises LAT cycles after accept.
REQ-021 In RESP, SHALL hold rsp_valid, rsp_data and rsp_err stable until an edge with rsp_ready high, then go to IDLE.
REQ-022 SHALL NOT accept a new request in the cycle its response is consumed; the earliest next accept is the following edge (no overlap, one outstanding transaction).
REQ-023 SHALL keep rf_write_enable low in every state other than WRITE.
REQ-024 SHALL ignore req_* inputs while busy, and rsp_ready outside RESP.

Reset
REQ-025 On rst, SHALL immediately and asynchronously force IDLE, counter=0, rsp_valid=0, rsp_data=0, rsp_err=0, rf_write_enable=0, rf_address=0, rf_datain=0, rf_mode=0, busy=0 and req_ready=1 after release.
REQ-026 rst asserted mid-write SHALL drop rf_write_enable in the same cycle, and the aborted transaction SHALL produce no response.

Configuration
REQ-027 Macro RFC_WRITE_VERIFY_EN defined: after WRITE, the FSM SHALL enter READ_WAIT with the same addr and mode, capture rf_dataout after LAT cycles, return the read value on rsp_data and set rsp_err = (read value != wdata); rsp_valid SHALL rise 1+LAT cycles after accept.
REQ-028 Macro RFC_WRITE_VERIFY_EN undefined: the FSM SHALL go WRITE->RESP directly, and rsp_err SHALL be constant 0.

Verification
REQ-029 Write addr 5, data 0xDEADBEEF, mode 0, rsp_ready=1 -> rf_write_enable high for exactly one cycle with rf_address=5; rsp_valid rises 1 cycle after accept with rsp_data=0xDEADBEEF.
REQ-030 Read addr 5 with mode 0, then with mode 1, against a regfile model of latency 2/3 -> rsp_valid rises 2 and 3 cycles after accept respectively, rsp_data=0xDEADBEEF both times.
REQ-031 Read with rsp_ready held low 4 cycles -> rsp_valid, rsp_data and busy stable for 4 cycles, req_ready low; the next accept occurs no earlier than 1 cycle after consumption.
REQ-032 rst asserted in the WRITE cycle -> rf_write_enable falls in the same cycle, no rsp_valid, and after release req_ready=1 and rf_address=0.
REQ-033 With RFC_WRITE_VERIFY_EN, write 0x12345678 to addr 31 while the model corrupts bit 0 -> rsp_valid rises 1+LAT cycles after accept with rsp_data=0x12345679 and rsp_err=1; with the model uncorrupted, rsp_err=0.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//
// Purpose:
//   Sequences one register-file access at a time between a valid/ready
//   request channel and a valid/ready response channel.
//   - Writes pulse rf_write_enable for exactly one cycle and then respond.
//   - Reads wait a mode-dependent latency (LAT_FAST for mode 0, LAT_SLOW
//     for mode 1), then capture rf_dataout as the response.
//   State and every output are registered.
//
// Optional feature (compile-time macro RFC_WRITE_VERIFY_EN):
//   When defined, each write is followed by a read-back of the same
//   address and mode. The response carries the read-back value, and
//   rsp_err flags a difference from the written data. When undefined,
//   writes respond with the written data and rsp_err is tied to 0.
//
// Parameters:
//   WIDTH    register data width
//   LAT_FAST read latency in cycles for mode 0 (>= 1)
//   LAT_SLOW read latency in cycles for mode 1 (>= 1)
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while IDLE)
//   req_write         1 = write, 0 = read
//   req_mode          latency select (0 = fast, 1 = slow)
//   req_addr          register address (5 bits)
//   req_wdata         write data
//   rsp_valid/ready   response handshake
//   rsp_data, rsp_err response data and verify-mismatch flag
//   rf_*              register-file side: write enable, address, data in,
//                     mode, and read data (rf_dataout)
//   busy              high in every state except IDLE
// ---------------------------------------------------------------------------
module regfile_access_ctrl #(
    parameter int WIDTH    = 32,
    parameter int LAT_FAST = 2,
    parameter int LAT_SLOW = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_mode,
    input  logic [4:0]       req_addr,
    input  logic [WIDTH-1:0] req_wdata,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,

    output logic             rf_write_enable,
    output logic [4:0]       rf_address,
    output logic [WIDTH-1:0] rf_datain,
    output logic             rf_mode,
    input  logic [WIDTH-1:0] rf_dataout,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RESP
    } state_t;

    // The counter only ever holds LAT-1, so it needs to reach LAT_MAX-1.
    localparam int LAT_MAX = (LAT_FAST > LAT_SLOW) ? LAT_FAST : LAT_SLOW;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOAD_FAST = CNT_W'(LAT_FAST - 1);
    localparam logic [CNT_W-1:0] LOAD_SLOW = CNT_W'(LAT_SLOW - 1);

    function automatic logic [CNT_W-1:0] load_for(input logic mode);
        return mode ? LOAD_SLOW : LOAD_FAST;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req_ready_d;
    logic             busy_d;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_d;
    logic             rf_write_enable_d;
    logic [4:0]       rf_address_d;
    logic [WIDTH-1:0] rf_datain_d;
    logic             rf_mode_d;

`ifdef RFC_WRITE_VERIFY_EN
    // Remembers that the current READ_WAIT is a write read-back, so the
    // captured value is compared against the data just written.
    logic             wr_q, wr_d;
    logic             rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data;
        rf_address_d = rf_address;
        rf_datain_d  = rf_datain;
        rf_mode_d    = rf_mode;
`ifdef RFC_WRITE_VERIFY_EN
        wr_d         = wr_q;
        rsp_err_d    = rsp_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    // Address and mode stay on the rf_* ports after the
                    // transaction, since they are only reloaded here.
                    rf_address_d = req_addr;
                    rf_mode_d    = req_mode;
                    rf_datain_d  = req_wdata;
`ifdef RFC_WRITE_VERIFY_EN
                    wr_d         = req_write;
`endif
                    if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ_WAIT;
                        cnt_d   = load_for(req_mode);
                    end
                end
            end

            WRITE: begin
`ifdef RFC_WRITE_VERIFY_EN
                state_d = READ_WAIT;
                cnt_d   = load_for(rf_mode);
`else
                state_d    = RESP;
                rsp_data_d = rf_datain;
`endif
            end

            READ_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    rsp_data_d = rf_dataout;
`ifdef RFC_WRITE_VERIFY_EN
                    rsp_err_d  = wr_q && (rf_dataout != rf_datain);
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so that, once registered,
        // they line up exactly with the state they describe.
        req_ready_d       = (state_d == IDLE);
        busy_d            = (state_d != IDLE);
        rsp_valid_d       = (state_d == RESP);
        rf_write_enable_d = (state_d == WRITE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, independent of statement order.
    // NOTE: every register here has a reset value; rf_write_enable must drop
    // the instant rst rises so an aborted write cannot land in the regfile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            req_ready       <= 1'b1;
            busy            <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rf_write_enable <= 1'b0;
            rf_address      <= '0;
            rf_datain       <= '0;
            rf_mode         <= 1'b0;
`ifdef RFC_WRITE_VERIFY_EN
            wr_q            <= 1'b0;
            rsp_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_ready       <= req_ready_d;
            busy            <= busy_d;
            rsp_valid       <= rsp_valid_d;
            rsp_data        <= rsp_data_d;
            rf_write_enable <= rf_write_enable_d;
            rf_address      <= rf_address_d;
            rf_datain       <= rf_datain_d;
            rf_mode         <= rf_mode_d;
`ifdef RFC_WRITE_VERIFY_EN
            wr_q            <= wr_d;
            rsp_err_q       <= rsp_err_d;
`endif
        end
    end

endmodule
